// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues reads to the synchronous instruction RAM and queues returned words for decode.
// First word is visible 2 edges after issue; a stalled decode holds the head while fetch fills the remaining queue slots.

// Generic flushable FIFO; read head is combinational from storage, pointers wrap on power-of-2 DEPTH.
// One-cycle push-to-visible latency; pushing when full or popping when empty is the caller's responsibility.
module fetch_pq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; occupancy is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic        push;
  logic        pop;
  entry_t      push_ent;
  entry_t      head_ent;

  // A slot is reserved at issue time, so the in-flight read counts against capacity.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_en     = !clear && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc[IMEM_AW-1:0];

  assign id_valid = (count != '0);
  assign id_instr = id_valid ? head_ent.instr : NOP;
  assign id_pc    = id_valid ? head_ent.pc    : 32'd0;

  // Redirect voids both the returning stale word and any concurrent consume.
  assign push     = inflight && !redirect;
  assign pop      = id_valid && id_ready && !redirect;
  assign push_ent = '{pc: inflight_pc, instr: imem_data};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd1;
      end
    end
  end

  fetch_pq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clock    (clock),
    .clear    (clear),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based reference model, plus directed reset/stall/redirect/wrap phases.
module tb_fetch_prefetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        clear;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;
  logic        w_ready = 1'b1;
  logic        w_en;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fetch_prefetch_queue #(.DEPTH(4), .IMEM_AW(8), .RESET_PC(32'd0), .NOP(NOP)) dut (
    .clock(clock), .clear(clear), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc));

  fetch_prefetch_queue #(.DEPTH(4), .IMEM_AW(8), .RESET_PC(32'hFE), .NOP(NOP)) dut_wrap (
    .clock(clock), .clear(clear), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .id_ready(w_ready), .imem_en(w_en), .imem_addr(w_addr), .imem_data(w_data),
    .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc));

  // Synchronous instruction RAM shared by both instances.
  always @(posedge clock) begin
    if (imem_en) imem_data <= mem[imem_addr];
    if (w_en)    w_data    <= mem[w_addr];
  end

  logic [31:0] wa [$];
  logic [31:0] wp [$];
  logic [31:0] wi [$];
  always @(negedge clock) begin
    if (!clear) begin
      if (w_en && wa.size() < 8) wa.push_back({24'd0, w_addr});
      if (w_valid && wp.size() < 8) begin
        wp.push_back(w_pc);
        wi.push_back(w_instr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: fetch pointer, one outstanding read, and an ordered list of buffered PCs.
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_infl;
  logic [31:0] q [$];

  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic [7:0]  s_addr;

  function automatic void m_reset();
    m_pc   = 32'd0;
    m_ipc  = 32'd0;
    m_infl = 1'b0;
    q.delete();
  endfunction

  function automatic bit m_issue();
    return !redirect && ((q.size() + int'(m_infl)) < 4);
  endfunction

  task automatic compare();
    logic [31:0] head;
    chk("imem_en", {31'd0, imem_en}, {31'd0, m_issue()});
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc[7:0]});
    chk("id_valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      head = q[0];
      chk("id_pc", id_pc, head);
      chk("id_instr", id_instr, mem[head[7:0]]);
    end else begin
      chk("id_pc_idle", id_pc, 32'd0);
      chk("id_instr_idle", id_instr, NOP);
    end
    s_valid = id_valid;
    s_pc    = id_pc;
    s_instr = id_instr;
    s_addr  = imem_addr;
  endtask

  function automatic void m_step();
    bit en;
    en = m_issue();
    if (redirect) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = redirect_pc;
    end else begin
      if (q.size() != 0 && id_ready) void'(q.pop_front());
      if (m_infl) q.push_back(m_ipc);
      m_infl = en;
      if (en) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd1;
      end
    end
  endfunction

  // One cycle: drive inputs, check mid-cycle, optionally pulse async reset, then advance the model at the edge.
  task automatic tick(input logic r, input logic [31:0] rp, input logic rdy, input bit pulse);
    redirect    = r;
    redirect_pc = rp;
    id_ready    = rdy;
    @(negedge clock);
    compare();
    if (pulse) begin
      #1 clear = 1'b1;
      #1;
      chk("rst_pulse_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_pulse_en", {31'd0, imem_en}, 32'd0);
      chk("rst_pulse_instr", id_instr, NOP);
      chk("rst_pulse_pc", id_pc, 32'd0);
      clear = 1'b0;
      m_reset();
    end
    @(posedge clock);
    m_step();
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
    clear = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
    m_reset();

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_en", {31'd0, imem_en}, 32'd0);
    chk("reset_valid", {31'd0, id_valid}, 32'd0);
    chk("reset_instr", id_instr, NOP);
    chk("reset_pc", id_pc, 32'd0);
    @(posedge clock);
    #1 clear = 1'b0;

    // T1: first word visible after the second edge, then one per cycle.
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 32'd0, 1'b1, 1'b0);
      if (k < 2) chk("t1_not_yet", {31'd0, s_valid}, 32'd0);
      else begin
        chk("t1_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_pc", s_pc, 32'(k - 2));
        chk("t1_instr", s_instr, 32'h100 + 32'(k - 2));
      end
    end

    // T2: stall then release.
    repeat (6) tick(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 32'd0, 1'b1, 1'b0);

    // T3/T4: reach three buffered plus one in flight, then redirect with a pop and push pending.
    n = 0;
    while (!(q.size() == 3 && m_infl) && n < 12) begin
      tick(1'b0, 32'd0, q.size() >= 4, 1'b0);
      n++;
    end
    chk("t3_setup", {31'd0, (q.size() == 3 && m_infl)}, 32'd1);
    tick(1'b1, 32'h40, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t3_valid_after", {31'd0, s_valid}, 32'd0);
    chk("t3_addr_after", {24'd0, s_addr}, 32'h40);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t3_gap", {31'd0, s_valid}, 32'd0);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t3_target_pc", s_pc, 32'h40);
    chk("t3_target_instr", s_instr, 32'h140);

    // T5: wrap instance ran from reset with id_ready high.
    chk("t5_addr_cnt", {31'd0, wa.size() >= 3}, 32'd1);
    chk("t5_pc_cnt", {31'd0, wp.size() >= 3}, 32'd1);
    if (wa.size() >= 3 && wp.size() >= 3) begin
      chk("t5_addr0", wa[0], 32'hFE);
      chk("t5_addr1", wa[1], 32'hFF);
      chk("t5_addr2", wa[2], 32'h00);
      chk("t5_pc0", wp[0], 32'hFE);
      chk("t5_pc1", wp[1], 32'hFF);
      chk("t5_pc2", wp[2], 32'h100);
      chk("t5_instr2", wi[2], 32'h100);
    end

    // T6: async reset pulse mid-stream, fetch restarts at the reset PC.
    repeat (3) tick(1'b0, 32'd0, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b1, 1'b1);
    repeat (4) tick(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized mix of stalls, redirects (including near 32-bit wrap) and rare reset pulses.
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic [31:0] rp;
      logic rdy;
      bit pulse;
      r     = ($urandom_range(99) < 6);
      rp    = ($urandom_range(3) == 0) ? (32'hFFFF_FFFD + 32'($urandom_range(3))) : $urandom;
      rdy   = ($urandom_range(99) < 70);
      pulse = !r && ($urandom_range(499) == 0);
      tick(r, rp, rdy, pulse);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
